// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, drives the word address to a combinational
// instruction memory and registers the returned word into a one-entry valid/ready stage.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_misaligned
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next_c;
    logic              can_load_c;
    logic              load_c;
    logic              drain_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; redirects never change the run/idle decision
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_enable)  state_next = RUN;
            RUN:     if (!fetch_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode: redirect beats load, load beats drain
    always_comb begin
        can_load_c = 1'b0;
        load_c     = 1'b0;
        drain_c    = 1'b0;
        pc_next_c  = pc;

        can_load_c = !if_valid || if_ready;
        load_c     = (state == RUN) && fetch_enable && !redirect_valid && can_load_c;
        drain_c    = !redirect_valid && !load_c && if_valid && if_ready;

        if (redirect_valid) begin
            pc_next_c = redirect_pc;
        end else if (load_c) begin
            pc_next_c = pc + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

    // One-entry output stage; a redirect flushes it even if decode is accepting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= '0;
            if_misaligned  <= 1'b0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (load_c) begin
            if_valid       <= 1'b1;
            if_instruction <= imem_instruction;
            if_pc          <= pc;
            if_misaligned  <= (pc[1:0] != 2'b00);
        end else if (drain_c) begin
            if_valid <= 1'b0;
        end
    end

    // Memory decodes words; byte offset bits are dropped, not trapped, here
    assign imem_address = {2'b00, pc[XLEN-1:2]};

endmodule
